key_event_scanner: RTL and testbench
====================================

// Module: key_event_scanner
// PURPOSE
//  Debounces the raw active-low push-button inputs (key_raw) ahead of the low-speed-bus key slave.
//  Turns every debounced press/release into an event byte in a small first-word-fall-through FIFO.
//  Raises a level IRQ toward the external interrupt controller while events are queued.
//  Sits between the board pins and the XT_LB key/switch register slave, which pops events.
// PARAMETERS
//  KEY_NUM          4      number of keys, 1..16
//  DEBOUNCE_CYCLES  20000  consecutive stable clk cycles required to accept a new level, >=2
//  FIFO_DEPTH       8      event FIFO entries, power of two, >=2
// PORTS
//  clk         in   1                          system clock
//  rst_sync    in   1                          synchronous reset, active-high
//  key_raw     in   KEY_NUM                    asynchronous raw keys, 0 = pressed
//  key_level   out  KEY_NUM                    debounced level, 1 = pressed
//  evt_pop     in   1                          pop FIFO head, 1-cycle strobe
//  evt_data    out  8                          head event: [7] valid, [6] 1=press/0=release, [5:4] 0, [3:0] key index
//  evt_count   out  $clog2(FIFO_DEPTH+1)       entries held
//  overflow    out  1                          sticky: an event was lost
//  ovf_clear   in   1                          clears overflow
//  irq_en      in   1                          interrupt enable
//  irq         out  1                          irq_en & (evt_count != 0), registered
// BEHAVIOUR
//  Reset (rst_sync=1 at posedge): sync flops = all 1 (released); key_level=0; counters=0; pending=0.
//   FIFO flushed; evt_count=0; evt_data=0; overflow=0; irq=0. Applies mid-debounce/mid-drain; queued events lost.
//  Sync: 2-flop synchronizer per key; s = ~sync2 (1 = pressed).
//  Debounce per key: if s == key_level, cnt <= 0.
//   Else if cnt == DEBOUNCE_CYCLES-1: key_level <= s, cnt <= 0, and a pending event is set (type = s).
//   Else cnt <= cnt+1.
//   Latency: raw edge -> key_level change = 2 + DEBOUNCE_CYCLES cycles if stable.
//   A glitch shorter than DEBOUNCE_CYCLES produces no change and no event.
//  Pending/arbiter: per key, one pending bit plus type.
//   Each cycle the lowest-index pending key is pushed into the FIFO and its pending bit is cleared.
//   The entry is visible at evt_data the next cycle if the FIFO was empty.
//   New transition on a key already pending: type overwritten, overflow <= 1.
//   Push when FIFO full and no pop the same cycle: event dropped, pending cleared, overflow <= 1.
//  FIFO: FWFT; evt_data[7] = (evt_count != 0); evt_data = 0 when empty.
//   Pop when empty: ignored.
//   Push+pop same cycle: both take effect, count unchanged (also when full).
//   Pointers wrap modulo FIFO_DEPTH.
//  overflow: set has priority over ovf_clear in the same cycle.
//  irq: registered; updates one cycle after evt_count/irq_en change.
// TESTING (sim with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, KEY_NUM=4)
//  1. key_raw[2] 1->0, held 10 cycles -> key_level[2]=1 exactly 6 cycles after the edge;
//     next cycle evt_data=8'hC2, evt_count=1; irq=1 one cycle later with irq_en=1.
//  2. key_raw[1] low for 3 cycles, then high -> key_level unchanged, evt_count stays 0.
//  3. keys 0 and 3 pressed in the same cycle -> two events in order 8'hC0, then 8'hC3, one cycle apart;
//     release of key 3 -> 8'h83.
//  4. Fill FIFO with 4 events, cause a 5th with no pop -> evt_count=4, overflow=1, head unchanged;
//     ovf_clear -> overflow=0.
//  5. FIFO full, pop in the same cycle a new event pushes -> evt_count stays 4, new event last;
//     pop on empty FIFO -> no change, evt_data=0.
//  6. rst_sync pulsed with 2 events queued and key 0 mid-debounce -> next cycle evt_count=0, irq=0,
//     key_level=0, overflow=0.

Source files
------------

// File: rtl/key_event_scanner.sv
// key_event_scanner: debounces active-low keys and queues press/release events with an IRQ
//   clk        system clock
//   rst_sync   synchronous reset, active-high
//   key_raw    asynchronous raw keys, 0 = pressed
//   key_level  debounced key level, 1 = pressed
//   evt_pop    pop FIFO head strobe
//   evt_data   head event {valid, press, 2'b00, key index}, 0 when empty
//   evt_count  entries held
//   overflow   sticky event-lost flag
//   ovf_clear  clears overflow
//   irq_en     interrupt enable
//   irq        registered irq_en & (evt_count != 0)
module key_event_scanner #(
    parameter int KEY_NUM         = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                              clk,
    input  logic                              rst_sync,
    input  logic [KEY_NUM-1:0]                key_raw,
    output logic [KEY_NUM-1:0]                key_level,
    input  logic                              evt_pop,
    output logic [7:0]                        evt_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   evt_count,
    output logic                              overflow,
    input  logic                              ovf_clear,
    input  logic                              irq_en,
    output logic                              irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    logic [KEY_NUM-1:0] sync1, sync2, s, accept, pend, ptype, grant;
    logic [CW-1:0]      cnt [KEY_NUM];
    logic [3:0]         sel;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               do_push, do_pop, lost;

    assign s = ~sync2;
    // lowest set pending bit, isolated as a one-hot grant
    assign grant   = pend & (~pend + KEY_NUM'(1));
    assign do_pop  = evt_pop && evt_count != 0;
    assign do_push = |pend && (evt_count != NW'(FIFO_DEPTH) || do_pop);
    // a pending event is lost if the FIFO refuses it, or if a new transition
    // lands on a key whose previous event is not being pushed this cycle
    assign lost     = (|pend && !do_push) || |(accept & pend & ~grant);
    assign evt_data = evt_count != 0 ? mem[rd_ptr] : 8'h00;

    always_comb begin
        sel = 4'd0;
        for (int k = 0; k < KEY_NUM; k++) begin
            accept[k] = s[k] != key_level[k] && cnt[k] == CW'(DEBOUNCE_CYCLES - 1);
            if (grant[k]) sel = 4'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            sync1     <= '1;
            sync2     <= '1;
            key_level <= '0;
            pend      <= '0;
            ptype     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
            irq       <= 1'b0;
            for (int k = 0; k < KEY_NUM; k++) cnt[k] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int k = 0; k < KEY_NUM; k++) begin
                if (s[k] == key_level[k]) cnt[k] <= '0;
                else if (accept[k]) begin
                    key_level[k] <= s[k];
                    cnt[k]       <= '0;
                end else cnt[k] <= cnt[k] + CW'(1);
            end
            pend      <= (pend & ~grant) | accept;
            ptype     <= (ptype & ~accept) | (s & accept);
            wr_ptr    <= wr_ptr + AW'(do_push);
            rd_ptr    <= rd_ptr + AW'(do_pop);
            evt_count <= evt_count + NW'(do_push) - NW'(do_pop);
            overflow  <= lost || (overflow && !ovf_clear);
            irq       <= irq_en && evt_count != 0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {1'b1, |(ptype & grant), 2'b00, sel};
    end
endmodule

// File: tb/tb_key_event_scanner.sv
// tb_key_event_scanner: directed scoreboard bench for key_event_scanner (4 keys, debounce 4, depth 4)
module tb_key_event_scanner;
    logic       clk = 1'b0;
    logic       rst_sync, evt_pop, ovf_clear, irq_en, overflow, irq;
    logic [3:0] key_raw, key_level;
    logic [7:0] evt_data;
    logic [2:0] evt_count;
    logic [7:0] q [$];
    int         n_checks = 0;
    int         n_fail = 0;

    key_event_scanner #(.KEY_NUM(4), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_sync(rst_sync), .key_raw(key_raw), .key_level(key_level),
        .evt_pop(evt_pop), .evt_data(evt_data), .evt_count(evt_count),
        .overflow(overflow), .ovf_clear(ovf_clear), .irq_en(irq_en), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] next_exp();
        return q.size() != 0 ? q.pop_front() : 8'hFF;
    endfunction

    task automatic drain(input string tag);
        for (int n = 0; n < 8 && evt_count != 0; n++) begin
            check({tag, "_head"}, evt_data, next_exp());
            evt_pop = 1'b1;
            step(1);
            evt_pop = 1'b0;
        end
        check({tag, "_drained"}, 8'(evt_count), 8'd0);
        check({tag, "_sb_empty"}, 8'(q.size()), 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sync = 1'b1; key_raw = 4'hF; evt_pop = 1'b0; ovf_clear = 1'b0; irq_en = 1'b1;
        step(3);
        rst_sync = 1'b0;
        step(1);
        check("rst_level", 8'(key_level), 8'h00);
        check("rst_count", 8'(evt_count), 8'h00);
        check("rst_data", evt_data, 8'h00);
        check("rst_ovf", 8'(overflow), 8'h00);
        check("rst_irq", 8'(irq), 8'h00);

        // press key 2: level rises 6 cycles after the edge, event one cycle later, irq one after that
        key_raw = 4'b1011; q.push_back(8'hC2);
        step(5);
        check("t1_level_early", 8'(key_level), 8'h00);
        step(1);
        check("t1_level", 8'(key_level), 8'h04);
        check("t1_count_pend", 8'(evt_count), 8'h00);
        step(1);
        check("t1_count", 8'(evt_count), 8'h01);
        check("t1_data", evt_data, q[0]);
        check("t1_irq_early", 8'(irq), 8'h00);
        step(1);
        check("t1_irq", 8'(irq), 8'h01);
        drain("t1");
        step(1);
        check("t1_irq_off", 8'(irq), 8'h00);
        key_raw = 4'b1111; q.push_back(8'h82);
        step(10);
        drain("t1_rel");

        // 3-cycle glitch on key 1 is rejected
        key_raw = 4'b1101;
        step(3);
        key_raw = 4'b1111;
        step(10);
        check("t2_level", 8'(key_level), 8'h00);
        check("t2_count", 8'(evt_count), 8'h00);

        // simultaneous press of keys 0 and 3: lower index first, one cycle apart
        key_raw = 4'b0110; q.push_back(8'hC0); q.push_back(8'hC3);
        step(7);
        check("t3_count1", 8'(evt_count), 8'h01);
        check("t3_first", evt_data, 8'hC0);
        step(1);
        check("t3_count2", 8'(evt_count), 8'h02);
        drain("t3");
        key_raw = 4'b1110; q.push_back(8'h83);
        step(10);
        drain("t3_rel");

        // four events fill the FIFO, a fifth is dropped
        key_raw = 4'b0001;
        q.push_back(8'h80); q.push_back(8'hC1); q.push_back(8'hC2); q.push_back(8'hC3);
        step(10);
        check("t4_full", 8'(evt_count), 8'h04);
        check("t4_ovf_clean", 8'(overflow), 8'h00);
        key_raw = 4'b0011;
        step(10);
        check("t4_count", 8'(evt_count), 8'h04);
        check("t4_ovf", 8'(overflow), 8'h01);
        check("t4_head", evt_data, q[0]);
        ovf_clear = 1'b1;
        step(1);
        ovf_clear = 1'b0;
        check("t4_ovf_clr", 8'(overflow), 8'h00);

        // pop while full in the same cycle a new event pushes
        key_raw = 4'b0111;
        step(6);
        check("t5_head", evt_data, next_exp());
        evt_pop = 1'b1;
        q.push_back(8'h82);
        step(1);
        evt_pop = 1'b0;
        check("t5_count", 8'(evt_count), 8'h04);
        check("t5_ovf", 8'(overflow), 8'h00);
        drain("t5");
        evt_pop = 1'b1;
        step(1);
        evt_pop = 1'b0;
        check("t5_empty_pop_cnt", 8'(evt_count), 8'h00);
        check("t5_empty_pop_data", evt_data, 8'h00);

        // reset with two events queued and key 0 mid-debounce
        key_raw = 4'b1101;
        step(10);
        check("t6_count", 8'(evt_count), 8'h02);
        check("t6_irq", 8'(irq), 8'h01);
        key_raw = 4'b1100;
        step(3);
        rst_sync = 1'b1;
        step(1);
        rst_sync = 1'b0;
        q.delete();
        check("t6_rst_count", 8'(evt_count), 8'h00);
        check("t6_rst_irq", 8'(irq), 8'h00);
        check("t6_rst_level", 8'(key_level), 8'h00);
        check("t6_rst_ovf", 8'(overflow), 8'h00);
        check("t6_rst_data", evt_data, 8'h00);
        // keys still held through reset are re-detected as fresh presses
        q.push_back(8'hC0); q.push_back(8'hC1);
        step(10);
        check("t6_relevel", 8'(key_level), 8'h03);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
